// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encoding and datapath mux/ALUOp codes shared by the multi-cycle controller
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BEQ, FAULT
  } state_t;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready memory cycles (clk, rst, clr, en in; timeout out when count==WAIT_MAX-1)
module mem_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || clr) ? '0 : en ? cnt + CNT_W'(1) : cnt;
  assign timeout = cnt == CNT_W'(WAIT_MAX - 1);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM (clk/reset, Opcode/Zero/MemReady in; mux selects, enables, strobes, ALUOp, Fault/FaultCause out)
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          ResultSrc,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Fault,
  output logic                FaultCause
);
  state_t state, next;
  logic cause, timeout, mem_state;
  logic [1:0] aluop;
  assign mem_state = state inside {FETCH, MEMRD, MEMWR};
  mem_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(reset),
    .clr(!mem_state || MemReady),
    .en(!MemReady),
    .timeout(timeout)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE: next = FETCH;
      FETCH, MEMRD, MEMWR: next = MemReady ? (state == FETCH ? DECODE : state == MEMRD ? MEMWB : FETCH)
                                           : timeout ? FAULT : state;
      DECODE: next = Opcode == OP_R ? EXECR : Opcode == OP_I ? EXECI
                   : (Opcode == OP_LOAD || Opcode == OP_STORE) ? MEMADR
                   : Opcode == OP_BRANCH ? BEQ : FAULT;
      EXECR, EXECI: next = ALUWB;
      MEMADR: next = Opcode == OP_LOAD ? MEMRD : MEMWR;
      FAULT: next = FAULT;
      default: next = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : next;
    cause <= reset ? 1'b0 : (next == FAULT && state != FAULT) ? mem_state : cause;
  end
  always_comb begin
    {PCWrite, IRWrite, AdrSrc, RegWrite, MemRead, MemWrite} = '0;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RS2;
    aluop = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    case (state)
      FETCH: begin MemRead = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU; IRWrite = MemReady; PCWrite = MemReady; end
      DECODE: begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      EXECR: begin ALUSrcA = SRCA_RS1; aluop = ALUOP_FUNCT; end
      EXECI: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; aluop = ALUOP_FUNCT; end
      ALUWB: RegWrite = 1'b1;
      MEMADR: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
      MEMRD: begin MemRead = 1'b1; AdrSrc = 1'b1; end
      MEMWB: begin RegWrite = 1'b1; ResultSrc = RES_MEM; end
      MEMWR: begin MemWrite = 1'b1; AdrSrc = 1'b1; end
      BEQ: begin ALUSrcA = SRCA_RS1; aluop = ALUOP_SUB; PCWrite = Zero; end
      default: ;
    endcase
  end
  assign ALUOp = ALUOP_W'(aluop);
  assign Fault = state == FAULT;
  assign FaultCause = Fault && cause;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random and directed stimulus checked every cycle against an instruction-step model
module tb_multicycle_controller;
  localparam int WAIT_MAX = 15;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  logic clk = 1'b0;
  logic reset, Zero, MemReady;
  logic [6:0] Opcode;
  logic PCWrite, IRWrite, AdrSrc, RegWrite, MemRead, MemWrite, Fault, FaultCause;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [15:0] outs;
  int n_cmp = 0, n_bad = 0;
  int len, memc, pcw, wb01, rwmap;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Fault(Fault), .FaultCause(FaultCause)
  );
  assign outs = {PCWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegWrite, MemRead, MemWrite, Fault, FaultCause};
  always #5 clk = ~clk;

  // Model: an instruction is a string of steps; F/R/S are memory steps that stall on MemReady.
  logic known = 1'b0, m_idle = 1'b1, m_fault = 1'b0, m_cause = 1'b0;
  string prog = "FD";
  int idx = 0, waits = 0;

  function automatic byte m_cur();
    return m_idle ? "0" : m_fault ? "Z" : prog[idx];
  endfunction

  function automatic logic [15:0] exp_out(input byte c, input logic z, input logic rdy, input logic cause);
    logic pcw_e, irw, adr, rw, mr, mw, flt, fc;
    logic [1:0] sa, sb, op, rs;
    {pcw_e, irw, adr, rw, mr, mw, flt, fc} = '0;
    sa = '0; sb = '0; op = '0; rs = '0;
    case (c)
      "F": begin mr = 1'b1; sb = 2'b10; rs = 2'b10; pcw_e = rdy; irw = rdy; end
      "D": begin sa = 2'b01; sb = 2'b01; end
      "X": begin sa = 2'b10; op = 2'b10; end
      "I": begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      "W": rw = 1'b1;
      "A": begin sa = 2'b10; sb = 2'b01; end
      "R": begin mr = 1'b1; adr = 1'b1; end
      "L": begin rw = 1'b1; rs = 2'b01; end
      "S": begin mw = 1'b1; adr = 1'b1; end
      "B": begin sa = 2'b10; op = 2'b01; pcw_e = z; end
      "Z": begin flt = 1'b1; fc = cause; end
      default: ;
    endcase
    return {pcw_e, irw, adr, sa, sb, op, rs, rw, mr, mw, flt, fc};
  endfunction

  always @(negedge clk) begin : cmp
    byte c;
    logic [15:0] e;
    c = m_cur();
    if (known) begin
      e = exp_out(c, Zero, MemReady, m_cause);
      n_cmp++;
      if (outs !== e) begin
        n_bad++;
        $display("FAIL model t=%0t step=%c got=%h exp=%h", $time, c, outs, e);
      end
    end
    if (reset) begin
      known = 1'b1; m_idle = 1'b1; m_fault = 1'b0; m_cause = 1'b0; waits = 0; prog = "FD"; idx = 0;
    end else if (known && !m_fault) begin
      if (m_idle) begin
        m_idle = 1'b0; prog = "FD"; idx = 0;
      end else if (c == "F" || c == "R" || c == "S") begin
        if (MemReady) begin
          waits = 0; idx++;
        end else if (waits == WAIT_MAX - 1) begin
          m_fault = 1'b1; m_cause = 1'b1;
        end else waits++;
      end else if (c == "D") begin
        case (Opcode)
          R: prog = "FDXW";
          I: prog = "FDIW";
          LD: prog = "FDARL";
          ST: prog = "FDAS";
          BR: prog = "FDB";
          default: begin m_fault = 1'b1; m_cause = 1'b0; end
        endcase
        idx = 2;
      end else idx++;
      if (!m_fault && idx >= prog.len()) begin prog = "FD"; idx = 0; end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic z, input logic rdy);
    reset = r; Opcode = op; Zero = z; MemReady = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b1, R, 1'b0, 1'b0);
    tick;
    tick;
    drive(1'b0, R, 1'b0, 1'b1);
    #1;
    chk("idle_outs", int'(outs), 0);
    tick;
  endtask

  // Runs one instruction from FETCH, holding MemReady low for the first nlow cycles of its data-memory step.
  task automatic instr(input logic [6:0] op, input logic z, input int nlow);
    int low;
    logic rdy, done;
    low = 0; done = 1'b0;
    len = 0; memc = 0; pcw = 0; wb01 = 0; rwmap = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      rdy = !(AdrSrc && low < nlow);
      if (!rdy) low++;
      drive(1'b0, op, z, rdy);
      #1;
      if (RegWrite) rwmap |= 1 << len;
      len++;
      if (AdrSrc && (MemRead || MemWrite)) memc++;
      if (PCWrite) pcw++;
      if (RegWrite && ResultSrc == 2'b01) wb01++;
      tick;
      done = Fault || (MemRead && !AdrSrc);
    end
    chk("instr_done", int'(done), 1);
  endtask

  function automatic logic [6:0] pick_op();
    int k;
    k = $urandom_range(0, 10);
    return k < 2 ? R : k < 4 ? I : k < 6 ? LD : k < 8 ? ST : k < 10 ? BR : 7'b0110111;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int s, stall;
    logic [6:0] op_r;
    logic r, rdy;
    do_reset;
    instr(R, 1'b0, 0);
    chk("r_len", len, 4);
    chk("r_regwrite_map", rwmap, 8);
    chk("r_pcwrite", pcw, 1);
    instr(LD, 1'b0, 3);
    chk("ld_len", len, 8);
    chk("ld_memrd_cycles", memc, 4);
    chk("ld_wb_mem", wb01, 1);
    instr(BR, 1'b1, 0);
    chk("beq_z1_len", len, 3);
    chk("beq_z1_pcwrite", pcw, 2);
    instr(BR, 1'b0, 0);
    chk("beq_z0_len", len, 3);
    chk("beq_z0_pcwrite", pcw, 1);
    instr(I, 1'b0, 0);
    chk("i_len", len, 4);
    instr(ST, 1'b0, 0);
    chk("st_len", len, 4);
    chk("st_memwr", memc, 1);
    instr(ST, 1'b0, 14);
    chk("st14_len", len, 18);
    chk("st14_memwr", memc, 15);
    chk("st14_nofault", int'(Fault), 0);
    instr(ST, 1'b0, 15);
    chk("st_to_memwr", memc, 15);
    chk("st_to_fault", int'(Fault), 1);
    chk("st_to_cause", int'(FaultCause), 1);
    do_reset;
    instr(7'b1111111, 1'b0, 0);
    chk("ill_len", len, 2);
    chk("ill_fault", int'(Fault), 1);
    chk("ill_cause", int'(FaultCause), 0);
    s = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 7'b1111111, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      s += int'(MemRead) + int'(MemWrite) + int'(RegWrite) + int'(PCWrite) + int'(IRWrite) + int'(!Fault);
      tick;
    end
    chk("ill_quiet", s, 0);
    do_reset;
    chk("ill_cleared", int'(Fault), 0);
    drive(1'b0, LD, 1'b0, 1'b1);
    tick;
    tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, LD, 1'b0, 1'b0);
      tick;
    end
    chk("midrd_in_memrd", int'(MemRead && AdrSrc), 1);
    drive(1'b1, LD, 1'b0, 1'b0);
    tick;
    drive(1'b0, ST, 1'b0, 1'b1);
    #1;
    chk("midrd_idle", int'(outs), 0);
    tick;
    instr(ST, 1'b0, 14);
    chk("midrd_cnt_cleared", len, 18);
    chk("midrd_nofault", int'(Fault), 0);
    op_r = R;
    stall = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_cur() == "F") op_r = pick_op();
      if (stall == 0 && $urandom_range(0, 60) == 0) stall = $urandom_range(10, 16);
      rdy = stall > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (stall > 0) stall--;
      r = $urandom_range(0, 99) == 0 || (m_cur() == "Z" && $urandom_range(0, 5) == 0);
      drive(r, op_r, 1'($urandom_range(0, 1)), rdy);
      tick;
    end
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
